// File: rtl/serial_nibble_cmp_ctrl_if.sv
// Operand/result bundle for the serial nibble comparator.
// The source drives start/A/B; the comparator returns busy/done and the result flags.
interface serial_nibble_cmp_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Greater;
    logic             Equal;
    logic [IDXW:0]    nib_count;

    modport master (
        output start, A, B,
        input  busy, done, Greater, Equal, nib_count
    );

    modport slave (
        input  start, A, B,
        output busy, done, Greater, Equal, nib_count
    );
endinterface

// File: rtl/serial_nibble_cmp_ctrl.sv
// Magnitude comparator walking one shared 4-bit slice from the top nibble down, exiting early.
// Define SIGNED_CMP_EN to compare two's-complement operands (sign bit flipped on the top nibble).
module serial_nibble_cmp_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    serial_nibble_cmp_ctrl_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IdxTop = IDXW'(NIB - 1);
    localparam logic [IDXW:0]   NibCnt = (IDXW + 1)'(NIB);

    typedef enum logic [0:0] {StIdle, StCmp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             done_q, done_d;
    logic             greater_q, greater_d;
    logic             equal_q, equal_d;
    logic [IDXW:0]    cnt_q, cnt_d;

    logic [3:0] na, nb;
    logic [3:0] na_c, nb_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ra_q      <= '0;
            rb_q      <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        na = ra_q[{idx_q, 2'b00} +: 4];
        nb = rb_q[{idx_q, 2'b00} +: 4];
`ifdef SIGNED_CMP_EN
        // Flipping the sign bit of the top nibble turns two's complement into offset binary.
        na_c = {na[3] ^ (idx_q == IdxTop), na[2:0]};
        nb_c = {nb[3] ^ (idx_q == IdxTop), nb[2:0]};
`else
        na_c = na;
        nb_c = nb;
`endif
    end

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        greater_d = greater_q;
        equal_d   = equal_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ra_d    = bus.A;
                    rb_d    = bus.B;
                    idx_d   = IdxTop;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                if (na_c > nb_c) begin
                    greater_d = 1'b1;
                    equal_d   = 1'b0;
                    done_d    = 1'b1;
                    cnt_d     = NibCnt - {1'b0, idx_q};
                    state_d   = StIdle;
                end else if (na_c < nb_c) begin
                    greater_d = 1'b0;
                    equal_d   = 1'b0;
                    done_d    = 1'b1;
                    cnt_d     = NibCnt - {1'b0, idx_q};
                    state_d   = StIdle;
                end else if (idx_q == '0) begin
                    greater_d = 1'b0;
                    equal_d   = 1'b1;
                    done_d    = 1'b1;
                    cnt_d     = NibCnt;
                    state_d   = StIdle;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == StCmp);
        bus.done      = done_q;
        bus.Greater   = greater_q;
        bus.Equal     = equal_q;
        bus.nib_count = cnt_q;
    end
endmodule

// File: tb/tb_serial_nibble_cmp_ctrl.sv
// Scoreboard bench for serial_nibble_cmp_ctrl at WIDTH=16: stimulus queues expected results,
// a negedge monitor pops and compares them on every done pulse.
module tb_serial_nibble_cmp_ctrl;
    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic       g;
        logic       e;
        logic [2:0] n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    serial_nibble_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_nibble_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.done) begin
                    check("done_width", {31'b0, prev_done}, 32'd0);
                    check("flags_exclusive", {31'b0, bus.Greater & bus.Equal}, 32'd0);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got done=1, expected no done");
                    end else begin
                        e = exp_q.pop_front();
                        check("Greater", {31'b0, bus.Greater}, {31'b0, e.g});
                        check("Equal", {31'b0, bus.Equal}, {31'b0, e.e});
                        check("nib_count", {29'b0, bus.nib_count}, {29'b0, e.n});
                    end
                end
                prev_done = bus.done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    // Present operands and return #1 after the accepting edge.
    task automatic start_cmp(input logic [15:0] a, input logic [15:0] b, input logic push,
                             input logic g, input logic e, input logic [2:0] n);
        @(posedge clk);
        #1;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        if (push) exp_q.push_back('{g: g, e: e, n: n});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    endtask

    // Count edges from the accepting edge until done; optionally poke start/A while busy.
    task automatic wait_done(input int k, input logic disturb);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (disturb && cyc == 1) begin
                bus.A     = 16'hFFFF;
                bus.start = 1'b1;
            end else if (disturb && cyc == 2) begin
                bus.start = 1'b0;
            end
        end while (!bus.done && cyc < 20);
        if (bus.done) begin
            check("latency", cyc, k);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done after %0d",
                     cyc, k);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int  cnt;
        logic sg;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_greater", {31'b0, bus.Greater}, 32'd0);
        check("rst_equal", {31'b0, bus.Equal}, 32'd0);
        check("rst_nib_count", {29'b0, bus.nib_count}, 32'd0);
        rst_n = 1'b1;

        start_cmp(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, 3'd4);
        wait_done(4, 1'b0);

        start_cmp(16'h9000, 16'h8FFF, 1'b1, 1'b1, 1'b0, 3'd1);
        wait_done(1, 1'b0);

        // A changed to FFFF and start pulsed mid-compare must not matter.
        start_cmp(16'h12A4, 16'h12B4, 1'b1, 1'b0, 1'b0, 3'd3);
        wait_done(3, 1'b1);
        count_dones(6, cnt);
        check("no_second_done", cnt, 0);

        start_cmp(16'hFFFF, 16'hFFFE, 1'b1, 1'b1, 1'b0, 3'd4);
        wait_done(4, 1'b0);

        start_cmp(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4);
        wait_done(4, 1'b0);

        // Back-to-back: start held high through done.
        @(posedge clk);
        #1;
        bus.A     = 16'h3000;
        bus.B     = 16'h4000;
        bus.start = 1'b1;
        exp_q.push_back('{g: 1'b0, e: 1'b0, n: 3'd1});
        exp_q.push_back('{g: 1'b1, e: 1'b0, n: 3'd4});
        @(posedge clk);
        #1;
        bus.A = 16'h0001;
        bus.B = 16'h0000;
        check("b2b_busy", {31'b0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        check("b2b_first_done", {31'b0, bus.done}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_done_pulse", {31'b0, bus.done}, 32'd0);
        check("b2b_second_busy", {31'b0, bus.busy}, 32'd1);
        wait_done(4, 1'b0);

`ifdef SIGNED_CMP_EN
        sg = 1'b1;
`else
        sg = 1'b0;
`endif
        start_cmp(16'h0001, 16'hFFFF, 1'b1, sg, 1'b0, 3'd1);
        wait_done(1, 1'b0);

        // Reset during the second CMP cycle of an equal compare.
        start_cmp(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_greater", {31'b0, bus.Greater}, 32'd0);
        check("abort_equal", {31'b0, bus.Equal}, 32'd0);
        check("abort_nib_count", {29'b0, bus.nib_count}, 32'd0);
        count_dones(8, cnt);
        check("abort_no_done", cnt, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_nibble_cmp_ctrl.md
Name: serial_nibble_cmp_ctrl

Overview:
- Sequenced magnitude comparator for wide operands. It reuses a single 4-bit compare slice across all nibbles of A and B, walking from the most-significant nibble down.
- Terminates early on the first unequal nibble.
- Trades latency for area compared with the parallel 16-bit comparator. Sits between an operand source with a start/done handshake and any consumer of Greater/Equal flags.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (localparam), number of nibbles examined.
- IDXW, clog2(NIB) with minimum 1 (localparam), width of the nibble index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a compare; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepted start.
- B  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- Greater  output  1  registered result, A > B.
- Equal  output  1  registered result, A == B.
- nib_count  output  IDXW+1  number of nibbles examined for the last result (1..NIB).

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While rst_n=0 at a rising edge:
  - state=IDLE, busy=0, done=0, Greater=0, Equal=0, nib_count=0.
  - Internal operand registers and idx cleared.
  - Reset mid-compare aborts the compare; no done is issued.
- State IDLE:
  - busy=0.
  - On start=1: latch A→ra, B→rb, idx=NIB-1, state→CMP.
  - done is cleared on the next edge (pulse width exactly 1).
- State CMP:
  - busy=1.
  - Combinational slice: na=ra[4*idx+3:4*idx], nb=rb[4*idx+3:4*idx], compared unsigned.
  - At each edge, exactly one of these applies:
    - na>nb: Greater=1, Equal=0, done=1, nib_count=NIB-idx, state→IDLE.
    - na<nb: Greater=0, Equal=0, done=1, nib_count=NIB-idx, state→IDLE.
    - na==nb and idx==0: Greater=0, Equal=1, done=1, nib_count=NIB, state→IDLE.
    - na==nb and idx>0: idx=idx-1, stay in CMP.
- Latency: start accepted at edge E; done is high in the cycle after edge E+k, where k is the nibbles examined (1..NIB).
  - Full-equal worst case: NIB cycles of busy.
- Results hold: Greater, Equal and nib_count remain stable from done until the next done. They do not clear on start.
- start while busy is ignored, and A/B changes while busy have no effect (operands are latched).
- start high in the same cycle done=1 (state IDLE) is accepted. Back-to-back throughput is one compare per k+1 cycles.
- Greater and Equal are never both 1.
- idx never underflows: the decision at idx==0 always exits CMP.

Optional Feature:
- Macro SIGNED_CMP_EN.
- When defined: operands are treated as two's complement. Only for the most-significant nibble (idx==NIB-1), bit 3 of both na and nb is inverted before the unsigned compare. Lower nibbles compare unsigned. Latency rules are unchanged.
- When undefined: all nibbles compare unsigned; behaviour is as above.

Test Plan:
- WIDTH=16. Reset with rst_n=0 for 2 cycles, then start with A=0x1234, B=0x1234 → busy for 4 cycles; done pulses with Equal=1, Greater=0, nib_count=4.
- A=0x9000, B=0x8FFF → done 1 cycle after the accepting edge; Greater=1, Equal=0, nib_count=1.
- A=0x12A4, B=0x12B4 → Greater=0, Equal=0, nib_count=3. Change A to 0xFFFF and pulse start while busy → result unaffected, no second done.
- Back-to-back: hold start=1 across done; second compare A=0x0001, B=0x0000 → Greater=1, nib_count=4; done pulses are exactly 1 cycle wide.
- Drop rst_n=0 for one cycle mid-compare (2nd CMP cycle of an equal compare) → busy=0, done never asserts, Greater=0, Equal=0, nib_count=0.
- With SIGNED_CMP_EN: A=0x0001, B=0xFFFF → Greater=1, nib_count=1. Without it → Greater=0, Equal=0, nib_count=1.
